// File: rtl/fetch_line_buffer.sv
// Single-line instruction prefetch buffer: zero-latency hits, in-order line refill on a miss.
// Refill stalls fetch (fetch_ready low) for 1 + LINE_WORDS + memory wait cycles; memory backpressure via mem_ready.
module fetch_line_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_BITS    = $clog2(LINE_WORDS);
  localparam int OFFSET_BITS = CNT_BITS + 2;
  localparam int TAG_BITS    = 32 - OFFSET_BITS;
  localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t              state;
  logic                line_valid;
  logic [TAG_BITS-1:0] line_tag;
  logic [31:0]         line_data [LINE_WORDS];
  logic [CNT_BITS-1:0] cnt;
  logic                flush_pending;

  logic [TAG_BITS-1:0] fetch_tag;
  logic [CNT_BITS-1:0] fetch_word;
  logic                hit;
  logic                beat;
  logic                unused_addr_bits;

  assign fetch_tag        = fetch_address[31:OFFSET_BITS];
  assign fetch_word       = fetch_address[OFFSET_BITS-1:2];
  assign unused_addr_bits = ^fetch_address[1:0];

  assign hit  = line_valid && (line_tag == fetch_tag);
  assign beat = mem_req && mem_ready;

  assign fetch_ready = (state == IDLE) && hit && !flush;
  assign fetch_data  = line_data[fetch_word];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      line_valid    <= 1'b0;
      line_tag      <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A flush only invalidates; the refill follows from the miss it causes next cycle.
          if (flush) begin
            line_valid <= 1'b0;
          end else if (!hit) begin
            state      <= REFILL;
            line_tag   <= fetch_tag;
            line_valid <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= {fetch_tag, {OFFSET_BITS{1'b0}}};
          end
        end
        REFILL: begin
          if (flush) flush_pending <= 1'b1;
          if (beat) begin
            cnt      <= cnt + CNT_BITS'(1);
            mem_addr <= mem_addr + 32'd4;
            if (cnt == LAST_WORD) begin
              // The line is kept only if no flush arrived at any point during its refill.
              mem_req       <= 1'b0;
              state         <= IDLE;
              line_valid    <= !(flush_pending || flush);
              flush_pending <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == REFILL && beat) line_data[cnt] <= mem_rdata;
  end

endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Bus-side responder for the fetch stage's instruction port. It answers every `fetch_address` with `fetch_data` in the same cycle when the addressed word is held in a single-line prefetch buffer. On a miss it refills the whole line from the instruction memory bus through a valid/ready handshake. `fetch_ready` feeds the hazard unit, which stalls fetch whenever it is low.

## Interface
- `LINE_WORDS`, default 4: words per line; power of two, at least 2.
- `OFFSET_BITS`, derived as log2(`LINE_WORDS`) + 2; not overridable.
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `fetch_address`, input, 32: byte address from fetch. Bits [1:0] are ignored.
- `fetch_data`, output, 32: instruction word. Combinational from the buffer. Only meaningful while `fetch_ready` is high.
- `fetch_ready`, output, 1: combinational; high when `fetch_data` is valid for the current `fetch_address`.
- `flush`, input, 1: invalidate the buffer (fence.i, self-modifying code).
- `mem_req`, output, 1: registered memory read request.
- `mem_addr`, output, 32: registered, word-aligned read address.
- `mem_ready`, input, 1: memory accepts the request and returns data this cycle.
- `mem_rdata`, input, 32: read data, valid when `mem_req && mem_ready`.

## Operation
- **State:**
  - `line_valid`
  - `line_tag[31:OFFSET_BITS]`
  - `LINE_WORDS` x 32 data words
  - FSM with states IDLE and REFILL
  - word counter `cnt`, log2(`LINE_WORDS`) bits
  - `flush_pending`
- **Hit:** `hit = line_valid && line_tag == fetch_address[31:OFFSET_BITS]`.
- **Outputs:**
  - `fetch_ready = (state == IDLE) && hit && !flush`.
  - `fetch_data` = data word `fetch_address[OFFSET_BITS-1:2]`, independent of `fetch_ready`.
- **IDLE:**
  - If `!hit || flush`, and `flush` is low: go to REFILL.
  - On entering REFILL: `line_tag <= fetch_address[31:OFFSET_BITS]`, `line_valid <= 0`, `cnt <= 0`, `mem_req <= 1`, `mem_addr <= {fetch_address[31:OFFSET_BITS], 0}`.
  - If `flush` is high in IDLE: `line_valid <= 0` only, and stay in IDLE. The refill starts the next cycle on the resulting miss.
- **REFILL:**
  - While `mem_req && !mem_ready`: hold `mem_req` and `mem_addr` stable.
  - On `mem_req && mem_ready`: write `mem_rdata` to word `cnt`, `cnt <= cnt + 1`, `mem_addr <= mem_addr + 4`. `mem_req` stays high, so back-to-back beats run one word per cycle.
  - On the beat where `cnt == LINE_WORDS-1`: `mem_req <= 0`, state <= IDLE, `line_valid <= !(flush_pending || flush)`, `flush_pending <= 0`.
- **Refill order:** words are fetched strictly in order from the line base; there is no critical-word-first.
- **Address change during REFILL** (branch, trap, mret): the refill is not aborted. It completes, then IDLE re-evaluates the new address.
- **`flush` during REFILL:** sets `flush_pending`. The completed line is discarded (`line_valid` stays 0).
- **Address arithmetic:** `mem_addr` increments modulo 2^32. A line never crosses an aligned `LINE_WORDS`*4 boundary, so the increment never changes the tag bits within a refill.
- **Reset** (any state, including mid-refill):
  - Registers: IDLE, `line_valid` 0, `flush_pending` 0, `cnt` 0, `mem_req` 0, `mem_addr` 0, `line_tag` 0.
  - Data words are not reset.
  - An in-flight memory request is abandoned; the memory shares `reset` and drops it too.
- **Reset outputs:** `fetch_ready` is 0 after reset, because `line_valid` is 0.

## Timing
- **Hit:** zero latency; `fetch_data`/`fetch_ready` are combinational from `fetch_address`.
- **Miss, zero-wait memory:**
  - Miss seen in cycle 0.
  - `mem_req` high in cycles 1..`LINE_WORDS`.
  - `fetch_ready` high in cycle `LINE_WORDS`+1.
- **Miss, general case:** miss-to-ready latency is 1 + `LINE_WORDS` + total wait cycles.
- **`mem_req` after refill:** low for at least one cycle (the IDLE evaluation cycle) before any new refill.
- **`flush` in a hit cycle:** `fetch_ready` is 0 in that same cycle.
- **Miss after flush:** `mem_req` rises 2 cycles after the flush cycle (IDLE flush, then miss, then request).
- **`fetch_ready`** is never high while in REFILL.

## Test plan
- **Cold miss, zero-wait memory:** after reset, `fetch_address` = 0x100, `mem_ready`=1, memory returns addr+0xA000_0000.
  - `mem_addr` 0x100, 0x104, 0x108, 0x10C in cycles 1-4.
  - Cycle 5: `fetch_ready`=1, `fetch_data`=0xA000_0100.
- **Hits within the line:** then `fetch_address` 0x104, 0x10C, 0x108 on consecutive cycles.
  - `fetch_ready`=1 each cycle, with data 0xA000_0104, 0xA000_010C, 0xA000_0108.
  - `mem_req` stays 0.
- **Wait states and redirect mid-refill:** `mem_ready` toggles 0/1, and `fetch_address` changes 0x200→0x340 during the refill of 0x200.
  - `mem_addr` is held during wait cycles.
  - All 4 words of 0x200 complete.
  - Then a refill of 0x340 starts; `fetch_ready` is 0 throughout.
- **Flush in a hit cycle:** line 0x100 valid, `flush`=1 for one cycle at 0x104.
  - `fetch_ready`=0 that cycle.
  - Next cycle a miss; `mem_req` with `mem_addr`=0x100 two cycles after the flush.
- **Flush during refill, including on the last beat:** assert `flush` on the last refill beat.
  - `line_valid` ends 0.
  - An immediate new refill of the same line follows.
- **Reset mid-refill:** assert `reset` after 2 beats.
  - Next cycle `mem_req`=0, `fetch_ready`=0.
  - A following access to the same line misses and refills from its base address.
